// File: rtl/ps_pwm_pkg.sv
// Shared definitions for the phase-shifted PWM carrier scheduler: FSM encoding, carrier geometry, phase offsets.
// Pure package, no latency or flow control.
package ps_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_e;

  localparam int DEF_WIDTH_TRIANG = 6;

  function automatic int carrier_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int carrier_period(input int w);
    return 2 * ((1 << w) - 1);
  endfunction

  // Leg k is shifted by a quarter of 2^W*2, i.e. k*2^(W-1) counts.
  function automatic int phase_offset(input int w, input int k);
    return k * (1 << (w - 1));
  endfunction

  localparam int MAX = carrier_max(DEF_WIDTH_TRIANG);
  localparam int P   = carrier_period(DEF_WIDTH_TRIANG);

endpackage

// File: rtl/ps_pwm_carrier_scheduler_carrier_fold.sv
// Folds a phase index 0..P-1 into a triangular carrier value 0..MAX.
// Purely combinational, zero latency, no flow control.
module carrier_fold
  import ps_pwm_pkg::*;
#(
  parameter int W = DEF_WIDTH_TRIANG
) (
  input  logic [W:0]   x_i,
  output logic [W-1:0] y_o
);

  localparam logic [W:0] MAX_V = (W+1)'(carrier_max(W));
  localparam logic [W:0] P_V   = (W+1)'(carrier_period(W));

  logic [W-1:0] mirror;

  // Falling half: P-x always lands in 1..MAX-1, so W bits suffice.
  assign mirror = W'(P_V - x_i);
  assign y_o    = (x_i <= MAX_V) ? x_i[W-1:0] : mirror;

endmodule

// File: rtl/ps_pwm_carrier_scheduler.sv
// Four-leg PS-PWM carrier sequencer with valley start/stop, resync and shadowed duty; PWM legs 1 cycle after phase.
// No backpressure. CARRIER_PEAK_UPDATE_EN adds a duty transfer at the carrier peak as well as the valley.
module ps_pwm_carrier_scheduler
  import ps_pwm_pkg::*;
#(
  parameter int WIDTH_TRIANG = DEF_WIDTH_TRIANG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sync_in,
  input  logic [WIDTH_TRIANG-1:0] duty_in,
  input  logic                    duty_load,
  input  logic [3:0]              phase_en,
  output logic [WIDTH_TRIANG-1:0] carrier0,
  output logic [WIDTH_TRIANG-1:0] carrier1,
  output logic [WIDTH_TRIANG-1:0] carrier2,
  output logic [WIDTH_TRIANG-1:0] carrier3,
  output logic [3:0]              pwm_out,
  output logic [WIDTH_TRIANG-1:0] duty_active,
  output logic                    valley,
  output logic                    peak,
  output logic                    running
);

  localparam int W = WIDTH_TRIANG;
  localparam logic [W+1:0] P_EXT  = (W+2)'(carrier_period(W));
  localparam logic [W:0]   P_LAST = (W+1)'(carrier_period(W) - 1);
  localparam logic [W:0]   MAX_P  = (W+1)'(carrier_max(W));

  state_e         state_q;
  logic [W:0]     p_q;
  logic [W:0]     p_d;
  logic [W-1:0]   shadow_q;
  logic [W-1:0]   active_q;
  logic           pending_q;
  logic [3:0]     pwm_q;
  logic [W:0]     idx   [4];
  logic [W-1:0]   car   [4];
  logic           xfer;

  for (genvar k = 0; k < 4; k++) begin : g_leg
    localparam logic [W+1:0] OFF = (W+2)'(phase_offset(W, k));
    logic [W+1:0] sum;
    // One extra bit keeps p+offset exact; it never reaches 2P, so a single subtract reduces it.
    assign sum    = {1'b0, p_q} + OFF;
    assign idx[k] = (sum >= P_EXT) ? (W+1)'(sum - P_EXT) : sum[W:0];
    carrier_fold #(.W(W)) u_fold (.x_i(idx[k]), .y_o(car[k]));
  end

  assign carrier0    = car[0];
  assign carrier1    = car[1];
  assign carrier2    = car[2];
  assign carrier3    = car[3];
  assign pwm_out     = pwm_q;
  assign duty_active = active_q;
  assign running     = (state_q != IDLE);
  assign valley      = running && (p_q == '0);
  assign peak        = running && (p_q == MAX_P);

`ifdef CARRIER_PEAK_UPDATE_EN
  assign xfer = valley | peak;
`else
  assign xfer = valley;
`endif

  assign p_d = (sync_in || p_q == P_LAST) ? '0 : p_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= '0;
    end else begin
      if (xfer) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      // A load coinciding with a transfer stays pending for the next one.
      if (duty_load) begin
        shadow_q  <= duty_in;
        pending_q <= 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        pwm_q[k] <= running & phase_en[k] & (active_q > car[k]);
      end
      case (state_q)
        IDLE: begin
          p_q <= '0;
          if (enable) begin
            state_q  <= RUN;
            active_q <= shadow_q;
          end
        end
        RUN: begin
          p_q <= p_d;
          if (!enable) state_q <= STOP_PEND;
        end
        STOP_PEND: begin
          if (enable) begin
            state_q <= RUN;
            p_q     <= p_d;
          end else if (!sync_in && p_q == P_LAST) begin
            state_q <= IDLE;
            p_q     <= '0;
          end else begin
            p_q <= p_d;
          end
        end
        default: begin
          state_q <= IDLE;
          p_q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps_pwm_carrier_scheduler.sv
// Self-checking bench for ps_pwm_carrier_scheduler at W=6 against a cycle-level behavioural model.
// Honours CARRIER_PEAK_UPDATE_EN in the model when the macro is defined.
module tb_ps_pwm_carrier_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable, sync_in, duty_load;
  logic [5:0] duty_in;
  logic [3:0] phase_en;
  logic [5:0] carrier0, carrier1, carrier2, carrier3, duty_active;
  logic [3:0] pwm_out;
  logic       valley, peak, running;
  logic [5:0] car [4];

  int checks = 0;
  int errors = 0;

`ifdef CARRIER_PEAK_UPDATE_EN
  localparam bit PEAK_XFER = 1'b1;
`else
  localparam bit PEAK_XFER = 1'b0;
`endif

  // Model: carrier position, run/stop-request flags, shadow and active duty, expected PWM.
  int       mp;
  bit       mrun, mstop;
  int       msh, mact;
  bit [3:0] mpwm;

  ps_pwm_carrier_scheduler #(.WIDTH_TRIANG(6)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync_in(sync_in),
    .duty_in(duty_in), .duty_load(duty_load), .phase_en(phase_en),
    .carrier0(carrier0), .carrier1(carrier1), .carrier2(carrier2), .carrier3(carrier3),
    .pwm_out(pwm_out), .duty_active(duty_active),
    .valley(valley), .peak(peak), .running(running)
  );

  assign car[0] = carrier0;
  assign car[1] = carrier1;
  assign car[2] = carrier2;
  assign car[3] = carrier3;

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int mtri(input int x);
    return (x <= 63) ? x : 126 - x;
  endfunction

  function automatic int mcar(input int k);
    return mtri((mp + 32 * k) % 126);
  endfunction

  task automatic tick();
    bit v, pk;
    @(posedge clk);
    if (rst) begin
      mp = 0; mrun = 0; mstop = 0; msh = 0; mact = 0; mpwm = '0;
    end else begin
      v  = mrun && mp == 0;
      pk = mrun && mp == 63;
      for (int k = 0; k < 4; k++) mpwm[k] = mrun && phase_en[k] && (mact > mcar(k));
      if (!mrun && enable) mact = msh;
      if (v || (pk && PEAK_XFER)) mact = msh;
      if (duty_load) msh = int'(duty_in);
      if (!mrun) begin
        mp = 0;
        if (enable) begin mrun = 1; mstop = 0; end
      end else begin
        if (sync_in) mp = 0;
        else if (mstop && !enable && mp == 125) begin mrun = 0; mp = 0; end
        else mp = (mp + 1) % 126;
        mstop = !enable;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_p(input int target);
    for (int n = 0; n < 300 && mp != target; n++) tick();
    checks++;
    if (mp != target) begin errors++; $display("FAIL wait_p timeout target %0d now %0d", target, mp); end
  endtask

  task automatic test_reset();
    rst = 1; enable = 1; duty_in = 6'd5; duty_load = 1; sync_in = 0; phase_en = 4'hF;
    tick(); tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (duty_active !== 6'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", duty_active); end
    checks++; if (pwm_out !== 4'd0) begin errors++; $display("FAIL reset_pwm got %b want 0000", pwm_out); end
    checks++; if (valley !== 1'b0 || peak !== 1'b0) begin errors++; $display("FAIL reset_vp got %b%b want 00", valley, peak); end
    checks++;
    if (carrier0 !== 6'd0 || carrier1 !== 6'd32 || carrier2 !== 6'd62 || carrier3 !== 6'd30) begin
      errors++;
      $display("FAIL reset_carriers got %0d %0d %0d %0d want 0 32 62 30", carrier0, carrier1, carrier2, carrier3);
    end
    rst = 0; enable = 0; duty_load = 0;
    tick();
  endtask

  task automatic test_pwm_half();
    int hi [4];
    int nval;
    hi = '{0, 0, 0, 0}; nval = 0;
    duty_in = 6'd32; duty_load = 1; tick(); duty_load = 0;
    enable = 1; tick();
    for (int i = 0; i < 254; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (car[k] !== 6'(mcar(k))) begin errors++; $display("FAIL half_carrier%0d got %0d want %0d", k, car[k], mcar(k)); end
        if (i >= 2 && i < 128 && pwm_out[k]) hi[k]++;
      end
      checks++; if (pwm_out !== mpwm) begin errors++; $display("FAIL half_pwm got %b want %b", pwm_out, mpwm); end
      checks++; if (valley !== (mp == 0)) begin errors++; $display("FAIL half_valley got %b want %b", valley, mp == 0); end
      if (i >= 2 && valley === 1'b1) nval++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (hi[k] != 63) begin errors++; $display("FAIL half_duty leg%0d got %0d want 63", k, hi[k]); end
    end
    checks++; if (nval != 2) begin errors++; $display("FAIL half_valley_count got %0d want 2", nval); end
  endtask

  task automatic test_duty_update();
    int seen_p, exp_p;
    bit got;
    exp_p = PEAK_XFER ? 64 : 1;
    got = 0; seen_p = -1;
    wait_p(50);
    duty_in = 6'd10; duty_load = 1; tick(); duty_load = 0;
    checks++; if (duty_active !== 6'd32) begin errors++; $display("FAIL upd_hold got %0d want 32", duty_active); end
    for (int n = 0; n < 200 && !got; n++) begin
      tick();
      if (duty_active === 6'd10) begin got = 1; seen_p = mp; end
    end
    checks++; if (seen_p != exp_p) begin errors++; $display("FAIL upd_point got p=%0d want p=%0d", seen_p, exp_p); end
  endtask

  task automatic test_stop();
    int n, q;
    wait_p(40);
    enable = 0; n = 0;
    while (running === 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n != 86) begin errors++; $display("FAIL stop_edges got %0d want 86", n); end
    tick();
    checks++; if (pwm_out !== 4'd0 || carrier0 !== 6'd0 || running !== 1'b0) begin
      errors++; $display("FAIL stop_idle got pwm=%b c0=%0d run=%b want 0000 0 0", pwm_out, carrier0, running);
    end
    enable = 1; tick();
    wait_p(40);
    enable = 0; q = 40;
    for (int i = 0; i < 120; i++) begin
      if (i == 20) enable = 1;
      tick(); q = (q + 1) % 126;
      checks++;
      if (carrier0 !== 6'(mtri(q)) || carrier2 !== 6'(mtri((q + 64) % 126)) || running !== 1'b1) begin
        errors++; $display("FAIL stop_nogap got c0=%0d c2=%0d run=%b want %0d %0d 1", carrier0, carrier2, running, mtri(q), mtri((q + 64) % 126));
      end
    end
  endtask

  task automatic test_sync();
    wait_p(65);
    duty_in = 6'd20; duty_load = 1; tick(); duty_load = 0;
    wait_p(70);
    sync_in = 1; tick(); sync_in = 0;
    checks++; if (valley !== 1'b1 || carrier0 !== 6'd0) begin errors++; $display("FAIL sync_valley got v=%b c0=%0d want 1 0", valley, carrier0); end
    checks++; if (duty_active !== 6'd10) begin errors++; $display("FAIL sync_pre got %0d want 10", duty_active); end
    tick();
    checks++; if (duty_active !== 6'd20 || carrier0 !== 6'd1) begin errors++; $display("FAIL sync_xfer got d=%0d c0=%0d want 20 1", duty_active, carrier0); end
    enable = 0;
    for (int n = 0; n < 300 && running === 1'b1; n++) tick();
    sync_in = 1; tick(); sync_in = 0; tick();
    checks++;
    if (running !== 1'b0 || carrier0 !== 6'd0 || carrier1 !== 6'd32 || carrier2 !== 6'd62 || carrier3 !== 6'd30) begin
      errors++; $display("FAIL sync_idle got run=%b c=%0d %0d %0d %0d want 0 0 32 62 30", running, carrier0, carrier1, carrier2, carrier3);
    end
  endtask

  task automatic test_phase_mask();
    int hi0, hi2, rises;
    bit prev;
    hi0 = 0; hi2 = 0; rises = 0; prev = 0;
    duty_in = 6'd40; duty_load = 1; tick(); duty_load = 0;
    phase_en = 4'b0101; enable = 1; tick();
    for (int i = 0; i < 130; i++) begin
      tick();
      checks++; if (pwm_out !== mpwm || pwm_out[1] !== 1'b0 || pwm_out[3] !== 1'b0) begin
        errors++; $display("FAIL mask_pwm got %b want %b", pwm_out, mpwm);
      end
      if (i >= 2 && i < 128) begin
        hi0 += int'(pwm_out[0]); hi2 += int'(pwm_out[2]);
        if (pwm_out[0] && !prev) rises++;
      end
      prev = pwm_out[0];
    end
    checks++; if (hi0 != 79 || hi2 != 79) begin errors++; $display("FAIL mask_duty got %0d %0d want 79 79", hi0, hi2); end
    checks++; if (rises != 1) begin errors++; $display("FAIL mask_period got %0d rises want 1", rises); end
  endtask

  task automatic test_random();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      sync_in   = ($urandom_range(0, 59) == 0);
      duty_load = ($urandom_range(0, 9) == 0);
      duty_in   = 6'($urandom_range(0, 63));
      if (i % 200 == 0) phase_en = 4'($urandom_range(0, 15));
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (car[k] !== 6'(mcar(k))) begin errors++; $display("FAIL rnd_carrier%0d got %0d want %0d", k, car[k], mcar(k)); end
      end
      checks++; if (pwm_out !== mpwm) begin errors++; $display("FAIL rnd_pwm got %b want %b", pwm_out, mpwm); end
      checks++; if (duty_active !== 6'(mact)) begin errors++; $display("FAIL rnd_duty got %0d want %0d", duty_active, mact); end
      checks++; if (running !== mrun) begin errors++; $display("FAIL rnd_running got %b want %b", running, mrun); end
      checks++; if (valley !== (mrun && mp == 0) || peak !== (mrun && mp == 63)) begin
        errors++; $display("FAIL rnd_vp got %b%b want %b%b", valley, peak, mrun && mp == 0, mrun && mp == 63);
      end
    end
    enable = 0; sync_in = 0; duty_load = 0;
  endtask

  initial begin
    rst = 1; enable = 0; sync_in = 0; duty_load = 0; duty_in = '0; phase_en = '0;
    mp = 0; mrun = 0; mstop = 0; msh = 0; mact = 0; mpwm = '0;
    @(negedge clk);
    test_reset();
    test_pwm_half();
    test_duty_update();
    test_stop();
    test_sync();
    test_phase_mask();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
